buffer_read_out: RTL and testbench

- Reader/drain side of the four-queue key-entry buffer.
- Watches the four packed 18-bit queue images, picks a non-empty queue round-robin and presents its head entry on a valid/ready output handshake.
- After each accepted transfer it pulses a one-hot pop request back to the writer, then waits for the writer's shifted image to settle.
- Sits between the key-entry buffer and the display/consumer logic.

---
 rtl/buffer_read_out_pkg.sv | 27 ++
 rtl/buffer_read_out_if.sv | 24 ++
 rtl/buffer_read_out_rr_arbiter4.sv | 30 +++
 rtl/buffer_read_out.sv | 161 ++++++++++++++++
 tb/tb_buffer_read_out.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_read_out_pkg.sv
// Shared types and constants for the key-entry buffer read-out side.
package buffer_read_out_pkg;

    localparam int unsigned NUM_Q     = 4;
    localparam int unsigned DEPTH     = 6;
    localparam int unsigned ENTRY_W   = 3;
    localparam int unsigned IMG_W     = DEPTH * ENTRY_W;
    localparam int unsigned DATA_W    = 2;
    localparam int unsigned IDX_W     = 2;

    // Entry layout inside a queue image slot: {data[1:0], valid}
    localparam int unsigned VALID_BIT = 0;
    localparam int unsigned DATA_LSB  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        POP    = 2'd2,
        SETTLE = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              valid;
    } entry_t;

endpackage

// File: rtl/buffer_read_out_if.sv
// Valid/ready output handshake carrying one buffered key entry.
interface buffer_read_out_if;
    import buffer_read_out_pkg::*;

    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [IDX_W-1:0]  out_src_o;

    modport master (
        output out_valid_o,
        output out_data_o,
        output out_src_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        input  out_src_o,
        output out_ready_i
    );

endinterface

// File: rtl/buffer_read_out_rr_arbiter4.sv
// Four-way round-robin arbiter: first request found at ptr, ptr+1, ... mod 4.
module rr_arbiter4
    import buffer_read_out_pkg::*;
(
    input  logic [NUM_Q-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NUM_Q-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Rotating priority search starting at the pointer
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            cand = ptr_i + IDX_W'(i);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buffer_read_out.sv
// Drain side of the four-queue key-entry buffer: round-robin pick, offer head, pop, settle.
module buffer_read_out
    import buffer_read_out_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IMG_W-1:0]       buffer1_i,
    input  logic [IMG_W-1:0]       buffer2_i,
    input  logic [IMG_W-1:0]       buffer3_i,
    input  logic [IMG_W-1:0]       buffer4_i,
    output logic [NUM_Q-1:0]       pop_o,
    output logic [NUM_Q*CNT_W-1:0] served_o,
    output logic                   busy_o,
    buffer_read_out_if.master      out_if
);

    localparam int unsigned SETTLE_N = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int unsigned SET_W    = $clog2(SETTLE_N + 1);

    state_e state_q, state_d;

    entry_t           head_c [NUM_Q];
    logic [NUM_Q-1:0] req_c;
    logic [NUM_Q-1:0] gnt_c;
    logic [IDX_W-1:0] gidx_c;
    logic [DATA_W-1:0] sel_data_c;
    logic             accept_c;
    logic             unused_c;

    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SET_W-1:0]  settle_q, settle_d;

    logic [NUM_Q-1:0][CNT_W-1:0] served_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [IDX_W-1:0]  out_src_q;
    logic [NUM_Q-1:0]  pop_q;
    logic              busy_q;

    // Only the head slot of each image matters to the arbiter
    assign unused_c = ^{buffer1_i[IMG_W-1:ENTRY_W], buffer2_i[IMG_W-1:ENTRY_W],
                        buffer3_i[IMG_W-1:ENTRY_W], buffer4_i[IMG_W-1:ENTRY_W]};

    // Decode head entries and build the request vector
    always_comb begin
        head_c[0] = '{data: buffer1_i[DATA_LSB +: DATA_W], valid: buffer1_i[VALID_BIT]};
        head_c[1] = '{data: buffer2_i[DATA_LSB +: DATA_W], valid: buffer2_i[VALID_BIT]};
        head_c[2] = '{data: buffer3_i[DATA_LSB +: DATA_W], valid: buffer3_i[VALID_BIT]};
        head_c[3] = '{data: buffer4_i[DATA_LSB +: DATA_W], valid: buffer4_i[VALID_BIT]};
        for (int unsigned q = 0; q < NUM_Q; q++) begin
            req_c[q] = head_c[q].valid;
        end
    end

    rr_arbiter4 u_arb (
        .req_i (req_c),
        .ptr_i (rr_q),
        .gnt_o (gnt_c),
        .idx_o (gidx_c)
    );

    // One-hot AND-OR select of the granted head data
    always_comb begin
        sel_data_c = '0;
        for (int unsigned q = 0; q < NUM_Q; q++) begin
            if (gnt_c[q]) begin
                sel_data_c = sel_data_c | head_c[q].data;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; images are only sampled in IDLE so a stale head is never re-served
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        data_d   = data_q;
        rr_d     = rr_q;
        settle_d = settle_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_c) begin
                    state_d = OFFER;
                    grant_d = gidx_c;
                    data_d  = sel_data_c;
                end
            end
            OFFER: begin
                if (out_if.out_ready_i) begin
                    accept_c = 1'b1;
                    state_d  = POP;
                end
            end
            POP: begin
                rr_d     = grant_q + IDX_W'(1);
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == SET_W'(SETTLE_N - 1)) begin
                    settle_d = '0;
                    state_d  = IDLE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath, counters and registered outputs aligned with the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            grant_q     <= '0;
            data_q      <= '0;
            settle_q    <= '0;
            served_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            pop_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            settle_q <= settle_d;
            if (accept_c) begin
                served_q[grant_q] <= served_q[grant_q] + CNT_W'(1);
            end
            out_valid_q <= (state_d == OFFER);
            out_data_q  <= (state_d == OFFER) ? data_d  : '0;
            out_src_q   <= (state_d == OFFER) ? grant_d : '0;
            pop_q       <= (state_d == POP) ? (NUM_Q'(1) << grant_d) : '0;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign out_if.out_valid_o = out_valid_q;
    assign out_if.out_data_o  = out_data_q;
    assign out_if.out_src_o   = out_src_q;
    assign pop_o              = pop_q;
    assign busy_o             = busy_q;
    assign served_o           = served_q;

endmodule

// File: tb/tb_buffer_read_out.sv
// Bench for buffer_read_out: writer model, scoreboard, vector table and corner sequences.
module tb_buffer_read_out;
    import buffer_read_out_pkg::*;

    localparam int unsigned CNT_W         = 8;
    localparam int unsigned SETTLE_CYCLES = 2;

    typedef struct packed {
        logic [1:0] src;
        logic [1:0] data;
    } exp_t;

    typedef struct {
        int         q;
        logic [1:0] d;
        int         hold;
        logic [1:0] exp_src;
        logic [1:0] exp_data;
        logic [3:0] exp_pop;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [IMG_W-1:0]       img [NUM_Q];
    logic [NUM_Q-1:0]       pop;
    logic [NUM_Q*CNT_W-1:0] served;
    logic                   busy;

    buffer_read_out_if bus ();

    buffer_read_out #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buffer1_i (img[0]),
        .buffer2_i (img[1]),
        .buffer3_i (img[2]),
        .buffer4_i (img[3]),
        .pop_o     (pop),
        .served_o  (served),
        .busy_o    (busy),
        .out_if    (bus)
    );

    always #5 clk = ~clk;

    logic [1:0]  mq [NUM_Q][$];
    exp_t        sb [$];
    int unsigned served_exp [NUM_Q];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          pop_cyc = -1000;
    int          last_gap = 0;
    int          wr_delay = 0;
    int          pend_q = 0;
    int          pend_cnt = 0;
    logic [1:0]  last_src = 2'd0;
    logic        valid_prev = 1'b0;
    vec_t        tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Rebuild the four queue images from the writer model
    task automatic refresh();
        logic [IMG_W-1:0] v;
        for (int q = 0; q < int'(NUM_Q); q++) begin
            v = '0;
            for (int k = 0; k < mq[q].size() && k < int'(DEPTH); k++) begin
                v[k*ENTRY_W +: ENTRY_W] = {mq[q][k], 1'b1};
            end
            img[q] = v;
        end
    endtask

    task automatic load(input int q, input logic [1:0] d);
        mq[q].push_back(d);
        refresh();
    endtask

    task automatic expect_entry(input int q, input logic [1:0] d);
        exp_t e;
        e.src  = 2'(q);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic shift(input int q);
        if (mq[q].size() > 0) void'(mq[q].pop_front());
        refresh();
    endtask

    // One clock: score any handshake, advance, then react to the pop as the writer would
    task automatic tick();
        exp_t e;
        if (bus.out_valid_o && bus.out_ready_i) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got src %0d data %0d, want no offer", bus.out_src_o, bus.out_data_o);
            end else begin
                e = sb.pop_front();
                check("sb_src", 32'(bus.out_src_o), 32'(e.src));
                check("sb_data", 32'(bus.out_data_o), 32'(e.data));
                last_src = e.src;
                served_exp[e.src]++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus.out_valid_o && !valid_prev) last_gap = cyc - pop_cyc;
        valid_prev = bus.out_valid_o;
        if (pop != '0) begin
            check("pop_onehot", 32'(pop), 32'(4'b0001 << last_src));
            pop_cyc = cyc;
            if (wr_delay == 0) begin
                shift(int'(last_src));
            end else begin
                pend_q   = int'(last_src);
                pend_cnt = wr_delay;
            end
        end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) shift(pend_q);
        end
    endtask

    task automatic check_served();
        for (int q = 0; q < int'(NUM_Q); q++) begin
            check($sformatf("served_q%0d", q), 32'(served[q*CNT_W +: CNT_W]), 32'(served_exp[q] % 256));
        end
    endtask

    // Run until everything expected has been delivered and the reader is idle again
    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !busy && pend_cnt == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d entries outstanding, want 0", sb.size());
        end
        repeat (6) tick();
        check_served();
    endtask

    initial begin
        tbl[0] = '{1, 2'b11, 0,  2'd1, 2'b11, 4'b0010};
        tbl[1] = '{2, 2'b01, 10, 2'd2, 2'b01, 4'b0100};
        tbl[2] = '{0, 2'b10, 3,  2'd0, 2'b10, 4'b0001};
        tbl[3] = '{3, 2'b00, 0,  2'd3, 2'b00, 4'b1000};

        for (int q = 0; q < int'(NUM_Q); q++) served_exp[q] = 0;
        rst_n = 1'b0;
        bus.out_ready_i = 1'b0;
        refresh();
        repeat (3) @(negedge clk);

        // Reset state and quiet idle
        check("rst_outputs", 32'({bus.out_valid_o, bus.out_data_o, bus.out_src_o, pop, busy}), 32'd0);
        check("rst_served", 32'(served), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_quiet", 32'({bus.out_valid_o, pop, busy}), 32'd0);
        end
        check_served();

        // Single entries with varying backpressure
        for (int i = 0; i < 4; i++) begin
            bus.out_ready_i = (tbl[i].hold == 0);
            load(tbl[i].q, tbl[i].d);
            expect_entry(tbl[i].q, tbl[i].d);
            tick();
            check("offer_first", 32'({bus.out_valid_o, bus.out_src_o, bus.out_data_o}),
                  32'({1'b1, tbl[i].exp_src, tbl[i].exp_data}));
            for (int c = 0; c < tbl[i].hold; c++) begin
                tick();
                check("hold_stable", 32'({bus.out_valid_o, bus.out_src_o, bus.out_data_o, pop}),
                      32'({1'b1, tbl[i].exp_src, tbl[i].exp_data, 4'b0000}));
            end
            bus.out_ready_i = 1'b1;
            tick();
            check("pop_pulse", 32'({bus.out_valid_o, pop}), 32'({1'b0, tbl[i].exp_pop}));
            tick();
            check("pop_single", 32'({bus.out_valid_o, pop}), 32'd0);
            drain(50);
        end

        // Round-robin fairness: three entries in every queue
        for (int k = 0; k < 3; k++) begin
            for (int q = 0; q < int'(NUM_Q); q++) begin
                load(q, 2'(q + k));
                expect_entry(q, 2'(q + k));
            end
        end
        drain(200);

        // Pointer at 2 with queues 0 and 3 pending: queue 3 first
        load(1, 2'b01);
        expect_entry(1, 2'b01);
        drain(50);
        load(0, 2'b10);
        load(3, 2'b11);
        expect_entry(3, 2'b11);
        expect_entry(0, 2'b10);
        drain(80);

        // Delayed writer: no duplicate, next offer four cycles after the pop
        wr_delay = 2;
        load(2, 2'b01);
        load(2, 2'b10);
        expect_entry(2, 2'b01);
        expect_entry(2, 2'b10);
        drain(80);
        check("settle_gap", 32'(last_gap), 32'd4);
        wr_delay = 0;

        // Reset in OFFER drops the offer and clears counters and pointer
        bus.out_ready_i = 1'b0;
        load(1, 2'b10);
        expect_entry(1, 2'b10);
        tick();
        check("pre_rst_offer", 32'({bus.out_valid_o, bus.out_src_o, bus.out_data_o}), 32'({1'b1, 2'd1, 2'b10}));
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({bus.out_valid_o, bus.out_data_o, bus.out_src_o, pop, busy}), 32'd0);
        check("rst_mid_served", 32'(served), 32'd0);
        for (int q = 0; q < int'(NUM_Q); q++) served_exp[q] = 0;
        @(negedge clk);
        valid_prev = 1'b0;
        rst_n = 1'b1;
        load(3, 2'b01);
        expect_entry(3, 2'b01);
        tick();
        check("re_offer", 32'({bus.out_valid_o, bus.out_src_o, bus.out_data_o}), 32'({1'b1, 2'd1, 2'b10}));
        bus.out_ready_i = 1'b1;
        drain(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
